div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider in the EX stage, directly downstream of the register file. It consumes the two forwarded source operands (rdata1 = dividend, rdata2 = divisor) for DIV/DIVU. It produces {remainder, quotient} for the HI/LO write. While busy, EX holds `start` high and stalls the pipeline until `ready`.

## Interface
- `WIDTH`, default 32: operand width. Iteration count equals `WIDTH`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  divide request. Held high by EX until `ready`.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU. Sampled with `start`.
- `annul`  in  1  cancel the current operation (branch flush or exception).
- `opdata1`  in  WIDTH  dividend. Sampled when `start` is accepted.
- `opdata2`  in  WIDTH  divisor. Sampled when `start` is accepted.
- `result`  out  2*WIDTH  {remainder, quotient}. Registered.
- `ready`  out  1  result valid. Registered.

## Operation
- **States:** IDLE, DIV_ZERO, BUSY, DONE. Reset state is IDLE.
- **Reset values:** `result` = 0, `ready` = 0, iteration counter = 0.
- **IDLE:**
  - `start` && !`annul`: latch the operands.
    - Divisor == 0 → DIV_ZERO.
    - Otherwise → BUSY with counter = 0.
  - `annul` overrides `start`; stay in IDLE.
- **Operand conditioning on accept (signed_div = 1):**
  - Replace each negative operand with its two's-complement magnitude.
  - Record `neg_q` = sign1 XOR sign2.
  - Record `neg_r` = sign1.
- **BUSY (restoring, one quotient bit per cycle, MSB first):**
  - Form trial = {rem[WIDTH-2:0], next dividend bit} − divisor, in WIDTH+1 bits.
  - If trial ≥ 0: rem ← trial, quotient bit = 1.
  - Else: rem ← shifted value, quotient bit = 0.
  - When counter == WIDTH−1, the final iteration completes. Apply sign fix-up (negate quotient if `neg_q`, negate remainder if `neg_r`). Write `result`, go to DONE.
  - `annul` = 1 → IDLE next cycle. `result` is unchanged and `ready` never asserts.
- **DIV_ZERO:**
  - `result` ← 0, go to DONE.
  - `annul` = 1 → IDLE instead.
- **DONE:**
  - `ready` = 1 and `result` is stable.
  - `start` still high && !`annul`: stay in DONE. No new operation starts.
  - `start` low or `annul` high: go to IDLE, `ready` = 0 from the next cycle.
- **Corner case:** signed 0x80000000 / −1 gives quotient 0x80000000, remainder 0. No trap.
- **Result retention:** `result` keeps its last value outside DONE. It is valid only while `ready` = 1.

## Timing
- Cycle N: `start` accepted in IDLE.
- Nonzero divisor: BUSY in N+1..N+WIDTH. DONE and `ready` = 1 from N+WIDTH+1 (N+33 for WIDTH = 32).
- Zero divisor: DIV_ZERO at N+1, `ready` = 1 at N+2.
- `start` deasserted in DONE at cycle M: `ready` = 0 at M+1.
- Back-to-back: a new `start` is accepted in IDLE at M+1, no earlier.
- `rst` has priority over all inputs in every state:
  - next state is IDLE, and `ready`, `result` and the counter are cleared;
  - reset mid-BUSY discards the partial quotient.
- `annul` takes effect on the next edge in every state.
- Operand inputs are don't-care after acceptance. Changes on `opdata1`/`opdata2` during BUSY must not affect the result.

## Test plan
- **Unsigned divide:** DIVU 100 / 7 → `result` = {32'd2, 32'd14}, `ready` first high exactly 33 cycles after accept.
- **Signed divide:** DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- **Signed corners:** DIV 7 / 0xFFFFFFFE → q 0xFFFFFFFD, r 1. DIV 0x80000000 / 0xFFFFFFFF → q 0x80000000, r 0.
- **Divide by zero:** 5 / 0 → `result` = 0, `ready` at accept+2. DIVU 0xFFFFFFFF / 1 → q 0xFFFFFFFF, r 0.
- **Annul mid-operation:** start at N, `annul` pulse at N+10 → IDLE at N+11, `ready` stays 0. A new start of 9 / 3 at N+12 → {0, 3} at N+45.
- **Handshake and reset:**
  - Hold `start` for 5 cycles in DONE → `ready` and `result` stable; drop `start` → `ready` 0 next cycle.
  - Assert `rst` at accept+15 → `ready` = 0, `result` = 0, state IDLE.
  - Toggle the operands during BUSY → result unaffected.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient}; one quotient bit per cycle, MSB first.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ZERO = 2'd1,
    BUSY     = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dsr_q;
  logic [WIDTH-1:0]   rem_q;
  logic               negq_q;
  logic               negr_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic               sign1_s;
  logic               sign2_s;
  logic [WIDTH-1:0]   mag1_s;
  logic [WIDTH-1:0]   mag2_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH:0]     trial_s;
  logic               qbit_s;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   dvd_d;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  // Operand conditioning: signed operands become magnitudes on accept
  always_comb begin
    sign1_s = signed_div & opdata1[WIDTH-1];
    sign2_s = signed_div & opdata2[WIDTH-1];
    if (sign1_s) begin
      mag1_s = ~opdata1 + WIDTH'(1);
    end else begin
      mag1_s = opdata1;
    end
    if (sign2_s) begin
      mag2_s = ~opdata2 + WIDTH'(1);
    end else begin
      mag2_s = opdata2;
    end
  end

  // One restoring step; quotient bits shift into the vacated dividend LSBs
  always_comb begin
    shifted_s = {rem_q, dvd_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dsr_q};
    qbit_s    = ~trial_s[WIDTH];
    if (qbit_s) begin
      rem_d = trial_s[WIDTH-1:0];
    end else begin
      rem_d = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    end
    dvd_d = {dvd_q[WIDTH-2:0], qbit_s};
    if (negq_q) begin
      quo_fix_s = ~dvd_d + WIDTH'(1);
    end else begin
      quo_fix_s = dvd_d;
    end
    if (negr_q) begin
      rem_fix_s = ~rem_d + WIDTH'(1);
    end else begin
      rem_fix_s = rem_d;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (start && !annul) begin
            dvd_q  <= mag1_s;
            dsr_q  <= mag2_s;
            rem_q  <= '0;
            cnt_q  <= '0;
            negq_q <= sign1_s ^ sign2_s;
            negr_q <= sign1_s;
            if (opdata2 == '0) begin
              state_q <= DIV_ZERO;
            end else begin
              state_q <= BUSY;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (annul) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
              result_q <= {rem_fix_s, quo_fix_s};
              ready_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        DIV_ZERO: begin
          if (annul) begin
            state_q <= IDLE;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // Holding start keeps the result up; no new operation until IDLE
          if (start && !annul) begin
            state_q <= DONE;
          end else begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;

  int n_vec  = 0;
  int n_miss = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [31:0] qq;
    logic [31:0] rr;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qq = q[31:0];
      rr = r[31:0];
    end else begin
      qq = a / b;
      rr = a % b;
    end
    return {rr, qq};
  endfunction

  // Start an op (accepted at the next posedge) and wait for ready
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit tog, output logic [63:0] res, output int lat);
    start      = 1'b1;
    signed_div = s;
    opdata1    = a;
    opdata2    = b;
    annul      = 1'b0;
    lat        = 0;
    do begin
      @(negedge clk);
      lat++;
      if (tog) begin
        opdata1 = $urandom;
        opdata2 = $urandom;
      end
    end while (!ready && lat < 100);
    res = result;
  endtask

  task automatic release_start(input string name);
    start = 1'b0;
    @(negedge clk);
    check(name, {63'd0, ready}, 64'd0);
  endtask

  vec_t        tbl[7];
  logic [63:0] res;
  logic [63:0] exp;
  logic [63:0] last_exp;
  int          lat;
  int          highs;

  initial begin
    tbl[0] = '{32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                 33};
    tbl[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33};
    tbl[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1, 32'hFFFF_FFFD},          33};
    tbl[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0, 32'h8000_0000},          33};
    tbl[4] = '{32'd5,          32'd0,          1'b0, 64'd0,                           2};
    tbl[5] = '{32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0, 32'hFFFF_FFFF},          33};
    tbl[6] = '{32'hFFFF_FFFF,  32'd0,          1'b1, 64'd0,                           2};

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);

    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].s, 1'b0, res, lat);
      check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
      release_start($sformatf("tbl%0d_drop", i));
      last_exp = tbl[i].exp;
    end

    // Hold start in DONE for 5 cycles: ready and result stay put
    do_op(32'd1000, 32'd33, 1'b0, 1'b0, res, lat);
    exp = {32'd10, 32'd30};
    check("hold_result", res, exp);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_ready", i), {63'd0, ready}, 64'd1);
      check($sformatf("hold%0d_result", i), result, exp);
    end
    release_start("hold_drop");
    last_exp = exp;

    // Annul pulse at accept+10, then 9/3 started two cycles later
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd12345; opdata2 = 32'd17;
    @(negedge clk);
    repeat (9) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    check("annul_ready", {63'd0, ready}, 64'd0);
    check("annul_result_kept", result, last_exp);
    @(negedge clk);
    check("annul_ready_later", {63'd0, ready}, 64'd0);
    do_op(32'd9, 32'd3, 1'b0, 1'b0, res, lat);
    check("post_annul_result", res, {32'd0, 32'd3});
    check("post_annul_latency", 64'(lat), 64'd33);
    release_start("post_annul_drop");

    // Synchronous reset at accept+15 discards the operation
    start = 1'b1; signed_div = 1'b1; opdata1 = 32'hDEAD_BEEF; opdata2 = 32'd5;
    @(negedge clk);
    repeat (14) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready", {63'd0, ready}, 64'd0);
    check("rst_mid_result", result, 64'd0);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) highs++;
    end
    check("rst_mid_no_ready", 64'(highs), 64'd0);
    do_op(32'd77, 32'd7, 1'b0, 1'b0, res, lat);
    check("post_rst_result", res, {32'd0, 32'd11});
    check("post_rst_latency", 64'(lat), 64'd33);
    release_start("post_rst_drop");

    // Operand toggling during BUSY must not leak into the result
    do_op(32'hFFFF_FF9C, 32'd9, 1'b1, 1'b1, res, lat);
    check("toggle_result", res, ref_div(32'hFFFF_FF9C, 32'd9, 1'b1));
    check("toggle_latency", 64'(lat), 64'd33);
    release_start("toggle_drop");

    // Randomized operations against the reference
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 1000);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      do_op(a, b, s, i[0], res, lat);
      check($sformatf("rnd%0d_result a=%h b=%h s=%0d", i, a, b, s), res, ref_div(a, b, s));
      check($sformatf("rnd%0d_latency", i), 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
      release_start($sformatf("rnd%0d_drop", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
